// File: rtl/clk_burst_pkg.sv
// Shared constants and state encoding for the clk_burst_sched divider scheduler.
package clk_burst_pkg;

    localparam int DEF_SEL_W = 3;
    localparam int DEF_CNT_W = 8;
    localparam int PHASE_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        GUARD = 2'd3
    } state_t;

endpackage

// File: rtl/clk_burst_sched_rr_arbiter.sv
// Round-robin picker for clk_burst_sched; the search starts one past the last granted requester.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] pick
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] start_q;
    logic [IDX_W-1:0] pick_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_idx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(start_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                pick                = '0;
                pick[IDX_W'(idx)]   = 1'b1;
                pick_idx            = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
        end else if (advance) begin
            start_q <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/clk_burst_sched.sv
// Shares one power-of-two clock divider among NUM_REQ requesters, one burst at a time.
// Define CLK_BURST_SCHED_GUARD_EN to insert GUARD_CYC idle cycles after every burst.
module clk_burst_sched
    import clk_burst_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int GUARD_CYC = 2
) (
    input  logic                     CLK_IN,
    input  logic                     RST_N,
    input  logic [NUM_REQ-1:0]       REQ,
    input  logic [NUM_REQ*SEL_W-1:0] REQ_SEL,
    input  logic [NUM_REQ*CNT_W-1:0] REQ_LEN,
    output logic [NUM_REQ-1:0]       GNT,
    output logic [NUM_REQ-1:0]       DONE,
    output logic                     BUSY,
    output logic                     CLK_OUT,
    output logic                     RISE_STB
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   gnt_idx;
    logic [SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   period_cnt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] low_mask;
    logic [PHASE_W-1:0] full_mask;
    logic               abort_q;
    logic               done_q;
    logic               arb_adv;
    logic               req_held;
    logic               period_end;
    logic               burst_end;
    logic [CNT_W-1:0]   load_len;
    logic [SEL_W-1:0]   sel_arr [NUM_REQ];
    logic [CNT_W-1:0]   len_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign sel_arr[i] = REQ_SEL[i*SEL_W +: SEL_W];
        assign len_arr[i] = REQ_LEN[i*CNT_W +: CNT_W];
    end

    assign arb_adv = (state == IDLE) && (|REQ);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_in  (CLK_IN),
        .rst_n   (RST_N),
        .req     (REQ),
        .advance (arb_adv),
        .pick    (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    assign load_len   = len_arr[gnt_idx];
    assign req_held   = REQ[gnt_idx];
    assign low_mask   = (PHASE_W'(1) << sel_q) - PHASE_W'(1);
    assign full_mask  = {low_mask[PHASE_W-2:0], 1'b1};
    assign period_end = ((phase & full_mask) == full_mask);
    // A dropped request still finishes the current period so no high phase is cut short.
    assign burst_end  = (state == RUN) && period_end &&
                        (((period_cnt + CNT_W'(1)) == len_q) || abort_q || !req_held);

`ifdef CLK_BURST_SCHED_GUARD_EN
    localparam logic [7:0] GUARD_LAST = (GUARD_CYC <= 1) ? 8'd0 : 8'(GUARD_CYC - 1);
    logic [7:0] guard_cnt;
    logic       guard_done;

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N)              guard_cnt <= '0;
        else if (state == GUARD) guard_cnt <= guard_cnt + 8'd1;
        else                     guard_cnt <= '0;
    end

    assign guard_done = (guard_cnt == GUARD_LAST);
`endif

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|REQ) state_nxt = LOAD;
            LOAD: state_nxt = (load_len == '0) ? IDLE : RUN;
`ifdef CLK_BURST_SCHED_GUARD_EN
            RUN:   if (burst_end) state_nxt = GUARD;
            GUARD: if (guard_done) state_nxt = IDLE;
`else
            RUN:   if (burst_end) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            gnt_idx    <= '0;
            sel_q      <= '0;
            len_q      <= '0;
            phase      <= '0;
            period_cnt <= '0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (arb_adv) gnt_idx <= pick_idx;
                LOAD: begin
                    sel_q      <= sel_arr[gnt_idx];
                    len_q      <= load_len;
                    phase      <= '0;
                    period_cnt <= '0;
                    abort_q    <= 1'b0;
                    if (load_len == '0) done_q <= 1'b1;
                end
                RUN: begin
                    phase <= phase + PHASE_W'(1);
                    if (period_end) period_cnt <= period_cnt + CNT_W'(1);
                    if (!req_held)  abort_q    <= 1'b1;
                    if (burst_end)  done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        GNT      = '0;
        DONE     = '0;
        BUSY     = (state != IDLE);
        CLK_OUT  = 1'b0;
        RISE_STB = 1'b0;
        if (state == LOAD || state == RUN) GNT[gnt_idx] = 1'b1;
        if (done_q) DONE[gnt_idx] = 1'b1;
        if (state == RUN) begin
            CLK_OUT  = phase[sel_q];
            RISE_STB = ((phase & low_mask) == low_mask) && !phase[sel_q];
        end
    end

endmodule

// File: tb/tb_clk_burst_sched.sv
// Directed self-checking bench for clk_burst_sched with hand-computed cycle expectations.
module tb_clk_burst_sched;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 8;
`ifdef CLK_BURST_SCHED_GUARD_EN
    localparam int EXP_LAT = 5;
    localparam int EXP_GAP = 3;
`else
    localparam int EXP_LAT = 2;
    localparam int EXP_GAP = 0;
`endif

    logic                     CLK_IN;
    logic                     RST_N;
    logic [NUM_REQ-1:0]       REQ;
    logic [NUM_REQ*SEL_W-1:0] REQ_SEL;
    logic [NUM_REQ*CNT_W-1:0] REQ_LEN;
    logic [NUM_REQ-1:0]       GNT;
    logic [NUM_REQ-1:0]       DONE;
    logic                     BUSY;
    logic                     CLK_OUT;
    logic                     RISE_STB;

    int tests_run    = 0;
    int tests_failed = 0;

    int         first_gnt, done_cycle, first_high, high_cyc, rises, strobes, strobe_ok;
    logic [3:0] gnt_seen, done_seen, done_after;
    logic       prev_clk, prev_stb;

    clk_burst_sched #(
        .NUM_REQ   (NUM_REQ),
        .SEL_W     (SEL_W),
        .CNT_W     (CNT_W),
        .GUARD_CYC (3)
    ) dut (
        .CLK_IN   (CLK_IN),
        .RST_N    (RST_N),
        .REQ      (REQ),
        .REQ_SEL  (REQ_SEL),
        .REQ_LEN  (REQ_LEN),
        .GNT      (GNT),
        .DONE     (DONE),
        .BUSY     (BUSY),
        .CLK_OUT  (CLK_OUT),
        .RISE_STB (RISE_STB)
    );

    initial begin
        CLK_IN = 1'b0;
        forever #5 CLK_IN = ~CLK_IN;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] req_mask, input logic [11:0] sel,
                                 input logic [31:0] len);
        REQ_SEL = sel;
        REQ_LEN = len;
        REQ     = req_mask;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((BUSY || DONE != 0) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) checkOutput("idle_timeout", 0, 1);
    endtask

    // Cycle c is the cycle after the c-th rising edge following applyStimulus.
    task automatic collectBurst(input int max_cyc, input int drop_idx, input int drop_cyc,
                                input int scramble_cyc);
        first_gnt = -1; done_cycle = -1; first_high = -1;
        high_cyc = 0; rises = 0; strobes = 0; strobe_ok = 0;
        gnt_seen = '0; done_seen = '0; done_after = '0;
        prev_clk = 1'b0; prev_stb = 1'b0;
        for (int c = 1; c <= max_cyc && done_cycle < 0; c++) begin
            tick();
            if (c == drop_cyc) REQ[drop_idx] = 1'b0;
            if (c == scramble_cyc) begin
                REQ_SEL = ~REQ_SEL;
                REQ_LEN = ~REQ_LEN;
            end
            if (GNT != 0 && first_gnt < 0) begin
                first_gnt = c;
                gnt_seen  = GNT;
            end
            if (CLK_OUT) begin
                high_cyc++;
                if (first_high < 0) first_high = c;
            end
            if (CLK_OUT && !prev_clk) begin
                rises++;
                if (prev_stb) strobe_ok++;
            end
            if (RISE_STB) strobes++;
            prev_clk = CLK_OUT;
            prev_stb = RISE_STB;
            if (DONE != 0) begin
                done_cycle = c;
                done_seen  = DONE;
                REQ        = REQ & ~DONE;
            end
        end
        if (done_cycle < 0) begin
            checkOutput("burst_timeout", 0, 1);
        end else begin
            tick();
            done_after = DONE;
        end
    endtask

    initial begin
        logic [3:0] order [5];
        logic [3:0] prev_g;
        logic [3:0] gnt2_val;
        int         n_gnt, multi_gnt;
        int         gnt1_last, done1, gnt2_first, gap_busy, gap_clk, done2;

        REQ = '0; REQ_SEL = '0; REQ_LEN = '0;
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        #2;
        checkOutput("reset_gnt",  GNT,      0);
        checkOutput("reset_done", DONE,     0);
        checkOutput("reset_busy", BUSY,     0);
        checkOutput("reset_clk",  CLK_OUT,  0);
        checkOutput("reset_stb",  RISE_STB, 0);
        tick();
        #2 RST_N = 1'b1;
        tick();

        // Single request: sel=1 (period 4), len=3; select/length scrambled after LOAD.
        applyStimulus(4'b0001, 12'h001, 32'h0000_0003);
        collectBurst(40, 0, -1, 3);
        checkOutput("single_gnt_cycle",  first_gnt,  1);
        checkOutput("single_gnt_val",    gnt_seen,   4'b0001);
        checkOutput("single_first_high", first_high, 4);
        checkOutput("single_high_cyc",   high_cyc,   6);
        checkOutput("single_rises",      rises,      3);
        checkOutput("single_strobes",    strobes,    3);
        checkOutput("single_strobe_pos", strobe_ok,  3);
        checkOutput("single_done_cycle", done_cycle, 14);
        checkOutput("single_done_val",   done_seen,  4'b0001);
        checkOutput("single_done_width", done_after, 0);
        waitIdle();

        // Zero-length burst on requester 1.
        applyStimulus(4'b0010, 12'h010, 32'h0000_0000);
        collectBurst(20, 0, -1, -1);
        checkOutput("zero_gnt_cycle",  first_gnt,  1);
        checkOutput("zero_done_cycle", done_cycle, 2);
        checkOutput("zero_done_val",   done_seen,  4'b0010);
        checkOutput("zero_high_cyc",   high_cyc,   0);
        waitIdle();

        // Abort: requester 2, sel=3 (period 16), len=5, REQ dropped mid-period 2.
        applyStimulus(4'b0100, 12'h0C0, 32'h0005_0000);
        collectBurst(120, 2, 25, -1);
        checkOutput("abort_first_high", first_high, 10);
        checkOutput("abort_rises",      rises,      2);
        checkOutput("abort_high_cyc",   high_cyc,   16);
        checkOutput("abort_strobes",    strobes,    2);
        checkOutput("abort_done_cycle", done_cycle, 34);
        checkOutput("abort_done_val",   done_seen,  4'b0100);
        waitIdle();

        // Asynchronous reset during a CLK_OUT high phase (requester 2, sel=2, len=4).
        applyStimulus(4'b0100, 12'h080, 32'h0004_0000);
        for (int c = 1; c <= 7; c++) tick();
        checkOutput("rst_pre_clk",  CLK_OUT, 1);
        checkOutput("rst_pre_busy", BUSY,    1);
        checkOutput("rst_pre_gnt",  GNT,     4'b0100);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("rst_async_clk",  CLK_OUT, 0);
        checkOutput("rst_async_gnt",  GNT,     0);
        checkOutput("rst_async_busy", BUSY,    0);
        checkOutput("rst_async_done", DONE,    0);
        REQ = '0;
        tick();
        checkOutput("rst_hold_done", DONE, 0);
        #2 RST_N = 1'b1;
        tick();

        // Contention: all four requesting, sel=0, len=1; pointer restarts at 0 after reset.
        applyStimulus(4'b1111, 12'h000, 32'h0101_0101);
        n_gnt = 0; multi_gnt = 0; prev_g = '0;
        for (int c = 1; c <= 60 && n_gnt < 5; c++) begin
            tick();
            if ($countones(GNT) > 1) multi_gnt++;
            if (GNT != 0 && prev_g == 0) begin
                order[n_gnt] = GNT;
                n_gnt++;
            end
            prev_g = GNT;
        end
        REQ = '0;
        checkOutput("cont_grants", n_gnt, 5);
        for (int k = 0; k < n_gnt; k++) begin
            checkOutput($sformatf("cont_order%0d", k), order[k], 1 << (k % 4));
        end
        checkOutput("cont_onehot", multi_gnt, 0);
        waitIdle();

        // Back-to-back: requesters 1 and 3; measures grant latency and guard gap.
        applyStimulus(4'b1010, 12'h000, 32'h0101_0101);
        gnt1_last = -1; done1 = -1; gnt2_first = -1; gnt2_val = '0;
        gap_busy = 0; gap_clk = 0; done2 = -1;
        for (int c = 1; c <= 60 && done2 < 0; c++) begin
            tick();
            if (GNT == 4'b0010) gnt1_last = c;
            if (DONE == 4'b0010) begin
                done1  = c;
                REQ[1] = 1'b0;
            end
            if (done1 > 0 && gnt2_first < 0) begin
                if (GNT != 0) begin
                    gnt2_first = c;
                    gnt2_val   = GNT;
                end else if (BUSY) begin
                    gap_busy++;
                    if (CLK_OUT) gap_clk++;
                end
            end
            if (DONE == 4'b1000) begin
                done2  = c;
                REQ[3] = 1'b0;
            end
        end
        checkOutput("b2b_second_done", (done2 > 0) ? 1 : 0, 1);
        checkOutput("b2b_gnt2_val",    gnt2_val, 4'b1000);
        checkOutput("b2b_latency",     gnt2_first - gnt1_last, EXP_LAT);
        checkOutput("b2b_guard_busy",  gap_busy, EXP_GAP);
        checkOutput("b2b_guard_clk",   gap_clk,  0);
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
